ib: RTL and testbench

IB -- requirements
Module: ib

---
 rtl/ib.sv | 130 +++++++++++++
 tb/tb_ib.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ib.sv
// Router input buffer: circular flit FIFO plus a two-state routing FSM
// that raises a one-hot output-port request for the packet at the FIFO top.
module ib #(
    parameter int unsigned PKTW  = 9,
    parameter int unsigned DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [PKTW:0] pkti,
    output logic [PKTW:0] pkto,
    output logic [3:0]    req,
    input  logic          ack,
    output logic          empty,
    output logic          full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] T_IDLE = 2'b00;
    localparam logic [1:0] T_HEAD = 2'b10;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_ACTIVE
    } state_t;

    logic [PKTW:0]   r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    state_t          r_state;
    logic [3:0]      r_req;

    state_t          w_state_nxt;
    logic [3:0]      w_req_nxt;
    logic [PKTW:0]   w_top;
    logic [1:0]      w_top_type;
    logic [1:0]      w_in_type;
    logic            w_empty;
    logic            w_full;
    logic            w_write;
    logic            w_read;
    logic            w_discard;
    logic            w_pop;

    assign w_top      = r_mem[r_rd_ptr];
    assign w_top_type = w_top[PKTW -: 2];
    assign w_in_type  = pkti[PKTW -: 2];
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(DEPTH));

    // A full FIFO drops arrivals even when a pop frees a slot this cycle.
    assign w_write    = (w_in_type != T_IDLE) && !w_full;
    assign w_read     = ack && !w_empty && (r_req != 4'b0000);
    // Stray non-head flits seen while idle are thrown away to resync.
    assign w_discard  = (r_state == S_IDLE) && !w_empty && (w_top_type != T_HEAD);
    assign w_pop      = w_read || w_discard;

    assign pkto  = w_read ? w_top : '0;
    assign req   = r_req;
    assign empty = w_empty;
    assign full  = w_full;

    // Flit storage; reset only blocks the write, contents are don't-care.
    always_ff @(posedge clk) begin
        if (rst && w_write) begin
            r_mem[r_wr_ptr] <= pkti;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_write, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Routing FSM state and registered request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_req   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
        end
    end

    // Next state: claim a port on a head, release it when the tail leaves.
    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        case (r_state)
            S_IDLE: begin
                w_req_nxt = 4'b0000;
                if (!w_empty && (w_top_type == T_HEAD)) begin
                    w_state_nxt = S_ACTIVE;
                    w_req_nxt   = 4'b0001 << w_top[1:0];
                end
            end
            S_ACTIVE: begin
                if (w_read && (w_top_type == T_TAIL)) begin
                    w_state_nxt = S_IDLE;
                    w_req_nxt   = 4'b0000;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_req_nxt   = 4'b0000;
            end
        endcase
    end

endmodule

// File: tb/tb_ib.sv
// Directed bench for ib: expected forwarded flits are queued as they are
// sent and a negedge monitor pops and compares every non-idle pkto.
module tb_ib;

    localparam int unsigned PKTW = 9;

    logic          clk = 1'b0;
    logic          rst;
    logic [PKTW:0] pkti;
    logic [PKTW:0] pkto;
    logic [3:0]    req;
    logic          ack;
    logic          empty;
    logic          full;

    logic [PKTW:0] exp_q [$];
    logic [PKTW:0] mon_exp;
    int            n_vec = 0;
    int            n_err = 0;

    ib #(.PKTW(PKTW), .DEPTH(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .pkti  (pkti),
        .pkto  (pkto),
        .req   (req),
        .ack   (ack),
        .empty (empty),
        .full  (full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PKTW:0] f, input bit expect_out);
        pkti = f;
        if (expect_out) exp_q.push_back(f);
        step();
    endtask

    task automatic chk_pkto_idle(input string name);
        #1;
        chk(name, 32'(pkto), 32'h0);
    endtask

    // Scoreboard monitor: every forwarded flit must match the queue head.
    always @(negedge clk) begin
        if (rst === 1'b1 && pkto != '0) begin
            if (exp_q.size() == 0) begin
                chk("pkto_unexpected", 32'(pkto), 32'h0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("pkto_flit", 32'(pkto), 32'(mon_exp));
            end
        end
    end

    initial begin
        rst  = 1'b0;
        pkti = '0;
        ack  = 1'b0;
        step();
        rst = 1'b1;
        chk("rst_empty", 32'(empty), 32'h1);
        chk("rst_full",  32'(full),  32'h0);
        chk("rst_req",   32'(req),   32'h0);
        chk_pkto_idle("rst_pkto");

        // Single packet to port 0, ack raised on the third flit.
        send(10'h200, 1'b1);
        chk("p0_req_head_stored", 32'(req), 32'h0);
        chk("p0_not_empty", 32'(empty), 32'h0);
        send(10'h100, 1'b1);
        chk("p0_req", 32'(req), 32'h1);
        ack = 1'b1;
        send(10'h101, 1'b1);
        send(10'h302, 1'b1);
        pkti = '0;
        step();
        step();
        ack = 1'b0;
        chk("p0_req_after_tail", 32'(req), 32'h0);
        chk("p0_empty_end", 32'(empty), 32'h1);

        // Port 1 packet with a paused grant.
        send(10'h291, 1'b1);
        send(10'h1A5, 1'b1);
        chk("p1_req", 32'(req), 32'h2);
        ack = 1'b1;
        send(10'h15A, 1'b1);
        ack = 1'b0;
        send(10'h392, 1'b1);
        pkti = '0;
        chk_pkto_idle("p1_pkto_paused");
        chk("p1_req_paused", 32'(req), 32'h2);
        step();
        chk("p1_req_still_held", 32'(req), 32'h2);
        ack = 1'b1;
        step();
        step();
        step();
        ack = 1'b0;
        chk("p1_req_after_tail", 32'(req), 32'h0);
        chk("p1_empty_end", 32'(empty), 32'h1);

        // Fill to capacity; fifth flit dropped even with a pop that cycle.
        send(10'h203, 1'b1);
        send(10'h111, 1'b1);
        chk("full_req_p3", 32'(req), 32'h8);
        send(10'h122, 1'b1);
        chk("full_at_3", 32'(full), 32'h0);
        send(10'h333, 1'b1);
        chk("full_at_4", 32'(full), 32'h1);
        ack = 1'b1;
        send(10'h155, 1'b0);
        chk("full_after_drop_pop", 32'(full), 32'h0);
        pkti = '0;
        step();
        step();
        step();
        ack = 1'b0;
        chk("full_empty_end", 32'(empty), 32'h1);
        chk("full_req_end", 32'(req), 32'h0);

        // Stray body flit while idle is discarded without output.
        send(10'h1AA, 1'b0);
        pkti = '0;
        chk("stray_stored", 32'(empty), 32'h0);
        step();
        chk("stray_discarded", 32'(empty), 32'h1);
        chk("stray_req", 32'(req), 32'h0);

        // Back-to-back packets: port 0 then port 3.
        send(10'h200, 1'b1);
        send(10'h3F0, 1'b1);
        chk("b2b_req0", 32'(req), 32'h1);
        send(10'h203, 1'b1);
        send(10'h3FF, 1'b1);
        pkti = '0;
        ack  = 1'b1;
        step();
        step();
        chk("b2b_req_gap", 32'(req), 32'h0);
        chk_pkto_idle("b2b_pkto_gap");
        step();
        chk("b2b_req3", 32'(req), 32'h8);
        step();
        step();
        ack = 1'b0;
        chk("b2b_req_end", 32'(req), 32'h0);
        chk("b2b_empty_end", 32'(empty), 32'h1);

        // Reset in the middle of a buffered packet, with a write pending.
        send(10'h202, 1'b0);
        send(10'h1BB, 1'b0);
        chk("mid_req", 32'(req), 32'h4);
        rst  = 1'b0;
        pkti = 10'h1CC;
        step();
        rst  = 1'b1;
        pkti = '0;
        chk("mid_rst_req",   32'(req),   32'h0);
        chk("mid_rst_empty", 32'(empty), 32'h1);
        chk("mid_rst_full",  32'(full),  32'h0);
        chk_pkto_idle("mid_rst_pkto");
        ack = 1'b1;
        step();
        step();
        ack = 1'b0;
        chk("mid_rst_still_empty", 32'(empty), 32'h1);
        chk("mid_rst_req_idle", 32'(req), 32'h0);

        step();
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
